// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and width definitions for the ALU command driver.
package alu_pkg;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_OP_W       = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_CNT_W      = 16;

  localparam logic [DEF_OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [DEF_OP_W-1:0] OP_AND  = 4'h1;
  localparam logic [DEF_OP_W-1:0] OP_OR   = 4'h2;
  localparam logic [DEF_OP_W-1:0] OP_XOR  = 4'h3;
  localparam logic [DEF_OP_W-1:0] OP_ADD  = 4'h4;
  localparam logic [DEF_OP_W-1:0] OP_SUB  = 4'h5;
  localparam logic [DEF_OP_W-1:0] OP_MUL  = 4'h6;
  localparam logic [DEF_OP_W-1:0] OP_DIV  = 4'h7;
  localparam logic [DEF_OP_W-1:0] OP_MOD  = 4'h8;
  localparam logic [DEF_OP_W-1:0] OP_SHL  = 4'h9;
  localparam logic [DEF_OP_W-1:0] OP_SHR  = 4'hA;
  localparam logic [DEF_OP_W-1:0] OP_NOT  = 4'hB;
  localparam logic [DEF_OP_W-1:0] OP_INC  = 4'hC;
  localparam logic [DEF_OP_W-1:0] OP_DEC  = 4'hD;
  localparam logic [DEF_OP_W-1:0] OP_PASS = 4'hE;
  localparam logic [DEF_OP_W-1:0] OP_RST  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_RECOV   = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO buffering upstream ALU commands.
module cmd_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Extra MSB distinguishes full from empty when the index bits match.
  logic [PTR_W:0]   wptr_q;
  logic [PTR_W:0]   rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[PTR_W-1:0]];

  // Pointer update; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (PTR_W+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (PTR_W+1)'(1);
    end
  end

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Sequences buffered commands onto the breadboard ALU and returns its results.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned OP_W       = DEF_OP_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_error,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic [OP_W-1:0]   rsp_opcode,
  output logic              busy,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  error_cnt
);

  localparam int unsigned CMD_W = OP_W + 2 * DATA_W;

  state_e            state_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_error_q;
  logic [OP_W-1:0]   rsp_opcode_q;
  logic [CNT_W-1:0]  issued_cnt_q;
  logic [CNT_W-1:0]  error_cnt_q;

  logic [CMD_W-1:0]  fifo_wdata;
  logic [CMD_W-1:0]  fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [OP_W-1:0]   head_op;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;

  assign fifo_wdata = {cmd_opcode, cmd_a, cmd_b};
  assign fifo_push  = cmd_valid && !fifo_full;
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
  assign head_op    = fifo_rdata[CMD_W-1 -: OP_W];
  assign head_a     = fifo_rdata[2*DATA_W-1 -: DATA_W];
  assign head_b     = fifo_rdata[DATA_W-1:0];

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (fifo_wdata),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // One-command-in-flight sequencer with registered ALU drive, response and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= OP_W'(OP_NOP);
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
      rsp_opcode_q <= '0;
      issued_cnt_q <= '0;
      error_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_a_q      <= head_a;
            alu_b_q      <= head_b;
            alu_op_q     <= head_op;
            rsp_opcode_q <= head_op;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // ALU latches the command at this edge; park the opcode on NO-OP.
          alu_op_q <= OP_W'(OP_NOP);
          state_q  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (rsp_opcode_q == OP_W'(OP_RST)) begin
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            state_q     <= ST_RECOV;
          end else begin
            rsp_data_q  <= alu_result;
            rsp_error_q <= alu_error;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RECOV: begin
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q  <= 1'b0;
            issued_cnt_q <= issued_cnt_q + CNT_W'(1);
            error_cnt_q  <= error_cnt_q + CNT_W'(rsp_error_q);
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = !fifo_full;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_opcode = rsp_opcode_q;
  assign issued_cnt = issued_cnt_q;
  assign error_cnt  = error_cnt_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural breadboard ALU.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        alu_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_error;
  logic [3:0]  rsp_opcode;
  logic        busy;
  logic [15:0] issued_cnt;
  logic [15:0] error_cnt;

  logic [15:0] alu_ar;
  logic [15:0] alu_br;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_driver dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_error  (alu_error),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_error  (rsp_error),
    .rsp_opcode (rsp_opcode),
    .busy       (busy),
    .issued_cnt (issued_cnt),
    .error_cnt  (error_cnt)
  );

  // Breadboard ALU stand-in: {error, result}
  function automatic logic [16:0] alu_eval(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    logic [16:0] s;
    logic [31:0] p;
    s = 17'(a) + 17'(b);
    p = 32'(a) * 32'(b);
    case (op)
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_ADD:  return s;
      OP_SUB:  return {(a < b), 16'(a - b)};
      OP_MUL:  return {(|p[31:16]), p[15:0]};
      OP_DIV:  return (b == 16'd0) ? {1'b1, 16'd0} : {1'b0, 16'(a / b)};
      OP_MOD:  return (b == 16'd0) ? {1'b1, 16'd0} : {1'b0, 16'(a % b)};
      OP_SHL:  return {1'b0, 16'(a << b[3:0])};
      OP_SHR:  return {1'b0, 16'(a >> b[3:0])};
      default: return {1'b0, a};
    endcase
  endfunction

  // ALU registers load on every non-NO-OP edge; RST clears them; NO-OP holds output.
  always @(posedge clk) begin
    if (alu_opcode == OP_RST) begin
      alu_ar     <= 16'd0;
      alu_br     <= 16'd0;
      alu_result <= 16'd0;
      alu_error  <= 1'b0;
    end else if (alu_opcode != OP_NOP) begin
      alu_ar                  <= alu_a;
      alu_br                  <= alu_b;
      {alu_error, alu_result} <= alu_eval(alu_opcode, alu_a, alu_b);
    end else begin
      alu_error <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check_eq("push_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check_eq("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask

  logic [3:0]  t3_op  [5] = '{OP_AND, OP_DIV, OP_MOD, OP_SHL, OP_OR};
  logic [15:0] t3_a   [5] = '{16'd1, 16'd9801, 16'd209, 16'd1, 16'd2};
  logic [15:0] t3_b   [5] = '{16'd1, 16'd121, 16'd50, 16'd15, 16'd4};
  logic [15:0] t3_exp [5] = '{16'd1, 16'd81, 16'd9, 16'd32768, 16'd6};

  logic [3:0]  t6_op  [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_DIV, OP_SHL};
  logic [15:0] t6_a   [8] = '{16'd100, 16'd500, 16'hF0F0, 16'h00F0, 16'hAAAA, 16'd300, 16'd1000, 16'd3};
  logic [15:0] t6_b   [8] = '{16'd23, 16'd1, 16'hFF00, 16'h0F00, 16'hFFFF, 16'd200, 16'd8, 16'd4};
  logic [15:0] t6_exp [8] = '{16'd123, 16'd499, 16'hF000, 16'h0FF0, 16'h5555, 16'd60000, 16'd125, 16'd48};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    cmd_opcode = 4'd0;
    cmd_a      = 16'd0;
    cmd_b      = 16'd0;
    do_reset();

    // Reset state
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_alu_op", 32'(alu_opcode), 32'd0);
    check_eq("rst_alu_a", 32'(alu_a), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_issued", 32'(issued_cnt), 32'd0);

    // 1: ADD with 3-cycle latency
    push(OP_ADD, 16'd355, 16'd5);
    wait_rsp(c);
    check_eq("t1_latency", 32'(c), 32'd3);
    check_eq("t1_data", 32'(rsp_data), 32'd360);
    check_eq("t1_err", 32'(rsp_error), 32'd0);
    check_eq("t1_op", 32'(rsp_opcode), 32'd4);
    step();
    check_eq("t1_valid_drop", 32'(rsp_valid), 32'd0);
    check_eq("t1_issued", 32'(issued_cnt), 32'd1);

    // 2: overflow errors counted
    do_reset();
    push(OP_ADD, 16'd50000, 16'd50000);
    wait_rsp(c);
    check_eq("t2_add_err", 32'(rsp_error), 32'd1);
    step();
    push(OP_MUL, 16'd2500, 16'd2500);
    wait_rsp(c);
    check_eq("t2_mul_err", 32'(rsp_error), 32'd1);
    step();
    check_eq("t2_error_cnt", 32'(error_cnt), 32'd2);
    check_eq("t2_issued_cnt", 32'(issued_cnt), 32'd2);

    // 3: backpressure, FIFO fill, in-order drain
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(t3_op[i], t3_a[i], t3_b[i]);
    check_eq("t3_full", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t3_hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("t3_hold_data", 32'(rsp_data), 32'd1);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(c);
      check_eq("t3_data", 32'(rsp_data), 32'(t3_exp[i]));
      step();
    end
    check_eq("t3_issued", 32'(issued_cnt), 32'd5);

    // 4: RST clears ALU, then NO-OP returns cleared output
    do_reset();
    push(OP_ADD, 16'd10, 16'd20);
    wait_rsp(c);
    check_eq("t4_pre_add", 32'(rsp_data), 32'd30);
    step();
    push(OP_RST, 16'd7, 16'd9);
    wait_rsp(c);
    check_eq("t4_rst_latency", 32'(c), 32'd4);
    check_eq("t4_rst_data", 32'(rsp_data), 32'd0);
    check_eq("t4_rst_err", 32'(rsp_error), 32'd0);
    check_eq("t4_rst_op", 32'(rsp_opcode), 32'd15);
    step();
    push(OP_NOP, 16'd0, 16'd0);
    wait_rsp(c);
    check_eq("t4_nop_data", 32'(rsp_data), 32'd0);
    check_eq("t4_nop_err", 32'(rsp_error), 32'd0);
    check_eq("t4_nop_op", 32'(rsp_opcode), 32'd0);
    check_eq("t4_alu_a_reg", 32'(alu_ar), 32'd0);
    check_eq("t4_alu_b_reg", 32'(alu_br), 32'd0);
    step();

    // 5: reset asserted during CAPTURE with a queued command
    do_reset();
    push(OP_SUB, 16'd30000, 16'd25000);
    push(OP_ADD, 16'd1, 16'd1);
    step();
    check_eq("t5_pre_alu_a", 32'(alu_a), 32'd30000);
    check_eq("t5_pre_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("t5_rst_alu_a", 32'(alu_a), 32'd0);
    check_eq("t5_rst_alu_b", 32'(alu_b), 32'd0);
    check_eq("t5_rst_alu_op", 32'(alu_opcode), 32'd0);
    check_eq("t5_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (2) step();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) step();
    check_eq("t5_no_stale_rsp", 32'(rsp_valid), 32'd0);
    check_eq("t5_idle_busy", 32'(busy), 32'd0);
    push(OP_SUB, 16'd30000, 16'd25000);
    wait_rsp(c);
    check_eq("t5_sub_data", 32'(rsp_data), 32'd5000);
    check_eq("t5_sub_err", 32'(rsp_error), 32'd0);
    step();

    // 6: streaming with pop while full, checked against a scoreboard
    do_reset();
    begin
      int  idx;
      int  rcvd;
      int  e;
      bit  full_seen;
      bit  push_now;
      bit  acc_now;
      int  sb[$];
      idx = 0;
      rcvd = 0;
      full_seen = 1'b0;
      for (int cyc = 0; cyc < 300 && rcvd < 8; cyc++) begin
        if (idx < 8) begin
          cmd_valid  = 1'b1;
          cmd_opcode = t6_op[idx];
          cmd_a      = t6_a[idx];
          cmd_b      = t6_b[idx];
        end else begin
          cmd_valid = 1'b0;
        end
        rsp_ready = (cyc >= 20) && ((cyc % 3) != 2);
        push_now  = cmd_valid && cmd_ready;
        acc_now   = rsp_valid && rsp_ready;
        if (cmd_valid && !cmd_ready) full_seen = 1'b1;
        if (acc_now) begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("t6_data", 32'(rsp_data), 32'(t6_exp[e]));
            check_eq("t6_op", 32'(rsp_opcode), 32'(t6_op[e]));
          end else begin
            check_eq("t6_extra_rsp", 32'(rsp_valid), 32'd0);
          end
          rcvd++;
        end
        step();
        if (push_now) begin
          sb.push_back(idx);
          idx++;
        end
      end
      cmd_valid = 1'b0;
      check_eq("t6_full_seen", 32'(full_seen), 32'd1);
      check_eq("t6_pushed", 32'(idx), 32'd8);
      check_eq("t6_received", 32'(rcvd), 32'd8);
      check_eq("t6_sb_empty", 32'(sb.size()), 32'd0);
      step();
      check_eq("t6_issued", 32'(issued_cnt), 32'd8);
      check_eq("t6_idle", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
